// File: rtl/shim_pkg.sv
// ---------------------------------------------------------------------------
// shim_pkg
// Shared definitions for the shim block path: sync header codes, the IDLE
// control block payload and the block record type. Used by the single-queue
// shim buffer, the multi-queue shim buffer and the encoder.
// ---------------------------------------------------------------------------
package shim_pkg;

    localparam logic [1:0]  SYNC_DATA = 2'b10;
    localparam logic [1:0]  SYNC_CTRL = 2'b01;
    localparam logic [63:0] D_IDLE    = 64'h1E;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  c;
    } block_t;

endpackage

// File: rtl/shim_chan_fifo.sv
// ---------------------------------------------------------------------------
// shim_chan_fifo
// One per-channel block queue of the multi-queue shim buffer. The parent
// decides whether a push or pop happens this cycle; this module only stores
// the entries and keeps the pointers, the occupancy count and the flags.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_push, i_pop   qualified push / pop strobes from the parent
//   i_data_d/_c     payload and sync header written on push
//   o_head_d/_c     entry at the read pointer (head of queue)
//   o_empty/o_full  count == 0 / count == 2**DEPTH_LOG2
//   o_afull         count >= AFULL_THR
//   o_space         free entries (2**DEPTH_LOG2 - count)
// ---------------------------------------------------------------------------
module shim_chan_fifo
    import shim_pkg::*;
#(
    parameter int DWIDTH     = 64,
    parameter int CWIDTH     = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL_THR  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DWIDTH-1:0]     i_data_d,
    input  logic [CWIDTH-1:0]     i_data_c,
    output logic [DWIDTH-1:0]     o_head_d,
    output logic [CWIDTH-1:0]     o_head_c,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_afull,
    output logic [DEPTH_LOG2:0]   o_space
);

    localparam int                DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] THR_C   = (DEPTH_LOG2+1)'(AFULL_THR);

    logic [DWIDTH-1:0]     r_memD [DEPTH];
    logic [CWIDTH-1:0]     r_memC [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_memD[r_wrPtr] <= i_data_d;
            r_memC[r_wrPtr] <= i_data_c;
        end
    end

    // Pointers wrap naturally at their width; the count is one bit wider so
    // that a completely full queue is distinguishable from an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags come straight from the registered count.
    assign o_head_d = r_memD[r_rdPtr];
    assign o_head_c = r_memC[r_rdPtr];
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == DEPTH_C);
    assign o_afull  = (r_count >= THR_C);
    assign o_space  = DEPTH_C - r_count;

endmodule

// File: rtl/shim_mq_buf.sv
// ---------------------------------------------------------------------------
// shim_mq_buf
// Multi-channel shim buffer: NCH independent block queues (one per traffic
// class) written one channel per cycle and drained onto a single PCS-side
// block stream by a work-conserving round-robin selector. When nothing is
// served the IDLE control block is presented instead.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr, wr_ch             write strobe and target channel
//   w_data_d, w_data_c    block payload and sync header to write
//   rd                    downstream takes one block this cycle
//   r_data_d, r_data_c    output block (IDLE when r_valid = 0)
//   r_valid, r_ch         output is a dequeued entry / channel served
//   empty, full, afull    per-channel flags
//   space                 per-channel free entries, DEPTH_LOG2+1 bits each
//
// Optional feature (macro SHIM_MQ_BUF_DROP_CNT_EN):
//   drop_cnt              per-channel saturating 16-bit dropped-write counts
//   drop_pulse            per-channel one-cycle strobe on each dropped write
// ---------------------------------------------------------------------------
module shim_mq_buf
    import shim_pkg::*;
#(
    parameter int DWIDTH     = 64,
    parameter int CWIDTH     = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int NCH        = 4,
    parameter int AFULL_THR  = 12,
    localparam int CHW       = $clog2(NCH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic [CHW-1:0]                wr_ch,
    input  logic [DWIDTH-1:0]             w_data_d,
    input  logic [CWIDTH-1:0]             w_data_c,
    input  logic                          rd,
    output logic [DWIDTH-1:0]             r_data_d,
    output logic [CWIDTH-1:0]             r_data_c,
    output logic                          r_valid,
    output logic [CHW-1:0]                r_ch,
    output logic [NCH-1:0]                empty,
    output logic [NCH-1:0]                full,
    output logic [NCH-1:0]                afull,
    output logic [NCH*(DEPTH_LOG2+1)-1:0] space
`ifdef SHIM_MQ_BUF_DROP_CNT_EN
   ,output logic [NCH*16-1:0]             drop_cnt,
    output logic [NCH-1:0]                drop_pulse
`endif
);

    logic [DWIDTH-1:0] w_headD [NCH];
    logic [CWIDTH-1:0] w_headC [NCH];
    logic [NCH-1:0]    w_push;
    logic [NCH-1:0]    w_pop;
    logic [NCH-1:0]    w_wrHit;
    logic [2*NCH-1:0]  w_rotReq;
    logic [CHW-1:0]    w_off;
    logic [CHW:0]      w_sum;
    logic [CHW-1:0]    w_sel;
    logic              w_any;
    logic              w_take;
    logic [CHW-1:0]    r_rrPtr;

    // Round-robin search: the request vector is doubled and shifted down by
    // rr_ptr so the lowest set bit is the first non-empty channel at or after
    // rr_ptr. The offset is then added back modulo NCH.
    assign w_rotReq = {~empty, ~empty} >> r_rrPtr;

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rotReq[k]) begin
                w_any = 1'b1;
                w_off = CHW'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_rrPtr} + {1'b0, w_off};
    assign w_sel  = (w_sum >= (CHW+1)'(NCH)) ? CHW'(w_sum - (CHW+1)'(NCH)) : CHW'(w_sum);
    assign w_take = rd && w_any;

    // Per-channel push/pop qualification. A write to a full channel only goes
    // through when that same channel is being popped this cycle; a wr_ch with
    // no matching channel hits nothing and is discarded.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign w_wrHit[i] = wr && (wr_ch == CHW'(i));
        assign w_pop[i]   = w_take && (w_sel == CHW'(i));
        assign w_push[i]  = w_wrHit[i] && (!full[i] || w_pop[i]);

        shim_chan_fifo #(
            .DWIDTH     (DWIDTH),
            .CWIDTH     (CWIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2),
            .AFULL_THR  (AFULL_THR)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .i_push   (w_push[i]),
            .i_pop    (w_pop[i]),
            .i_data_d (w_data_d),
            .i_data_c (w_data_c),
            .o_head_d (w_headD[i]),
            .o_head_c (w_headC[i]),
            .o_empty  (empty[i]),
            .o_full   (full[i]),
            .o_afull  (afull[i]),
            .o_space  (space[i*(DEPTH_LOG2+1) +: DEPTH_LOG2+1])
        );
    end

    // The pointer moves to just past the channel served, so every channel
    // with data gets a turn before any channel is served twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (w_take) begin
            r_rrPtr <= (w_sel == CHW'(NCH - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    // Zero-latency output straight from the selected head, IDLE otherwise.
    assign r_valid  = w_take;
    assign r_ch     = w_sel;
    assign r_data_d = w_take ? w_headD[w_sel] : DWIDTH'(D_IDLE);
    assign r_data_c = w_take ? w_headC[w_sel] : CWIDTH'(SYNC_CTRL);

`ifdef SHIM_MQ_BUF_DROP_CNT_EN
    logic [NCH-1:0] w_drop;
    logic [15:0]    r_dropCnt [NCH];

    assign w_drop     = w_wrHit & full & ~w_pop;
    assign drop_pulse = w_drop;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) r_dropCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_drop[i] && (r_dropCnt[i] != 16'hFFFF)) begin
                    r_dropCnt[i] <= r_dropCnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_dropOut
        assign drop_cnt[i*16 +: 16] = r_dropCnt[i];
    end
`endif

endmodule

// File: tb/tb_shim_mq_buf.sv
// ---------------------------------------------------------------------------
// tb_shim_mq_buf
// Self-checking bench for shim_mq_buf. A reference model of per-channel
// queues plus a round-robin pointer predicts every output block; predictions
// go into a scoreboard that a negedge monitor drains whenever rd is high.
// Flags are compared against the model after every clock edge.
// ---------------------------------------------------------------------------
module tb_shim_mq_buf;
    import shim_pkg::*;

    localparam int NCH   = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 12;
    localparam int SPW   = DL + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wr;
    logic [1:0]           wr_ch;
    logic [63:0]          w_data_d;
    logic [1:0]           w_data_c;
    logic                 rd;
    logic [63:0]          r_data_d;
    logic [1:0]           r_data_c;
    logic                 r_valid;
    logic [1:0]           r_ch;
    logic [NCH-1:0]       empty;
    logic [NCH-1:0]       full;
    logic [NCH-1:0]       afull;
    logic [NCH*SPW-1:0]   space;
`ifdef SHIM_MQ_BUF_DROP_CNT_EN
    logic [NCH*16-1:0]    drop_cnt;
    logic [NCH-1:0]       drop_pulse;
`endif

    typedef struct {
        bit          valid;
        int          ch;
        logic [65:0] blk;
    } exp_t;

    exp_t        expQ [$];
    logic [65:0] chanQ [NCH][$];
    int          rrModel;
    int          dropModel [NCH];
    int          checks   = 0;
    int          failures = 0;

    shim_mq_buf dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .wr_ch      (wr_ch),
        .w_data_d   (w_data_d),
        .w_data_c   (w_data_c),
        .rd         (rd),
        .r_data_d   (r_data_d),
        .r_data_c   (r_data_c),
        .r_valid    (r_valid),
        .r_ch       (r_ch),
        .empty      (empty),
        .full       (full),
        .afull      (afull),
        .space      (space)
`ifdef SHIM_MQ_BUF_DROP_CNT_EN
       ,.drop_cnt   (drop_cnt),
        .drop_pulse (drop_pulse)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Compare flag outputs against the occupancy held in the model.
    task automatic checkOutput();
        logic [NCH-1:0]     eEmpty;
        logic [NCH-1:0]     eFull;
        logic [NCH-1:0]     eAfull;
        logic [NCH*SPW-1:0] eSpace;
        for (int i = 0; i < NCH; i++) begin
            int sz;
            sz = chanQ[i].size();
            eEmpty[i] = (sz == 0);
            eFull[i]  = (sz == DEPTH);
            eAfull[i] = (sz >= THR);
            eSpace[i*SPW +: SPW] = SPW'(DEPTH - sz);
        end
        cmp("empty", 66'(empty), 66'(eEmpty));
        cmp("full",  66'(full),  66'(eFull));
        cmp("afull", 66'(afull), 66'(eAfull));
        cmp("space", 66'(space), 66'(eSpace));
`ifdef SHIM_MQ_BUF_DROP_CNT_EN
        for (int i = 0; i < NCH; i++) begin
            cmp("drop_cnt", 66'(drop_cnt[i*16 +: 16]), 66'(dropModel[i]));
        end
`endif
    endtask

    // Drive one cycle of stimulus, predict its effect, then let the edge pass.
    task automatic applyStimulus(input bit iWr, input int iCh, input logic [63:0] iD,
                                 input logic [1:0] iC, input bit iRd);
        exp_t e;
        int   sel;
        wr       = iWr;
        wr_ch    = 2'(iCh);
        w_data_d = iD;
        w_data_c = iC;
        rd       = iRd;
        if (iRd) begin
            sel = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (rrModel + k) % NCH;
                if (sel < 0 && chanQ[c].size() > 0) sel = c;
            end
            if (sel >= 0) begin
                e.valid = 1'b1;
                e.ch    = sel;
                e.blk   = chanQ[sel].pop_front();
                rrModel = (sel + 1) % NCH;
            end else begin
                e.valid = 1'b0;
                e.ch    = 0;
                e.blk   = {D_IDLE, SYNC_CTRL};
            end
            expQ.push_back(e);
        end
        // The pop above is taken first, so a full channel being served
        // this cycle has room for the write.
        if (iWr && iCh < NCH) begin
            if (chanQ[iCh].size() < DEPTH) chanQ[iCh].push_back({iD, iC});
            else if (dropModel[iCh] < 65535) dropModel[iCh]++;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [1:0] rndHdr();
        return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NCH; i++) begin
            chanQ[i].delete();
            dropModel[i] = 0;
        end
        rrModel = 0;
    endtask

    task automatic doReset();
        wr = 1'b0;
        rd = 1'b0;
        reset = 1'b1;
        clearModel();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // Monitor: every cycle the downstream takes a block, compare against the
    // oldest prediction.
    always @(negedge clk) begin
        if (!reset && rd) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_underflow actual=r_valid=%0b required=no_output", r_valid);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checks++;
                if (r_valid !== e.valid || (e.valid && r_ch !== 2'(e.ch)) ||
                    {r_data_d, r_data_c} !== e.blk) begin
                    failures++;
                    $display("[TB] FAIL out_block actual=v%0b ch%0d %h required=v%0b ch%0d %h",
                             r_valid, r_ch, {r_data_d, r_data_c}, e.valid, e.ch, e.blk);
                end
            end
        end
    end

    initial begin
        logic [63:0] dLabel;
        reset = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        wr_ch = '0;
        w_data_d = '0;
        w_data_c = '0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;

        // Idle output from an empty buffer.
        $display("[TB] reset and idle");
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Fill ch2 past capacity, then drain in order.
        $display("[TB] fill ch2");
        for (int n = 0; n < 17; n++) applyStimulus(1, 2, rnd64(), rndHdr(), 0);
        for (int n = 0; n < 16; n++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Round-robin order across sparse channels.
        $display("[TB] round robin");
        doReset();
        applyStimulus(1, 0, 64'hA0, SYNC_DATA, 0);
        applyStimulus(1, 0, 64'hA1, SYNC_DATA, 0);
        applyStimulus(1, 1, 64'hB0, SYNC_DATA, 0);
        applyStimulus(1, 3, 64'hC0, SYNC_DATA, 0);
        applyStimulus(1, 3, 64'hC1, SYNC_DATA, 0);
        for (int n = 0; n < 6; n++) applyStimulus(0, 0, 0, 0, 1);

        // Write into a full channel while it is being popped.
        $display("[TB] full with simultaneous pop");
        doReset();
        for (int n = 0; n < 16; n++) applyStimulus(1, 1, rnd64(), rndHdr(), 0);
        applyStimulus(1, 1, 64'h0123_4567_89AB_CDEF, SYNC_DATA, 1);
        for (int n = 0; n < 17; n++) applyStimulus(0, 0, 0, 0, 1);

        // rd low holds everything, including the round-robin pointer.
        $display("[TB] rd held low");
        doReset();
        applyStimulus(1, 0, rnd64(), rndHdr(), 0);
        applyStimulus(1, 2, rnd64(), rndHdr(), 0);
        applyStimulus(1, 0, rnd64(), rndHdr(), 0);
        applyStimulus(0, 0, 0, 0, 1);
        for (int n = 0; n < 5; n++) applyStimulus(0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) applyStimulus(0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a cycle.
        $display("[TB] mid-cycle reset");
        doReset();
        for (int n = 0; n < 8; n++) applyStimulus(1, 0, rnd64(), rndHdr(), 0);
        for (int n = 0; n < 3; n++) applyStimulus(0, 0, 0, 0, 1);
        rd = 1'b0;
        wr = 1'b0;
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput();
        @(posedge clk);
        #3;
        reset = 1'b0;
        dLabel = 64'hDEAD;
        applyStimulus(1, 0, dLabel, SYNC_DATA, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Random traffic in two phases: write-heavy to reach full/drops,
        // then read-heavy to exercise arbitration with many channels active.
        $display("[TB] random traffic");
        doReset();
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, NCH - 1),
                          rnd64(), rndHdr(), $urandom_range(0, 99) < 35);
        end
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, NCH - 1),
                          rnd64(), rndHdr(), $urandom_range(0, 99) < 80);
        end
        for (int n = 0; n < 70; n++) applyStimulus(0, 0, 0, 0, 1);

        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        cmp("scoreboard_drained", 66'(expQ.size()), 66'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
